rd_rsp_inorder_fetch: RTL

//  Downstream consumer of the DMA read reorder buffer's fetch channel. Keeps the request

---
 rtl/rd_rsp_inorder_fetch_pkg.sv | 26 ++
 rtl/rd_rsp_inorder_fetch_sync_fifo.sv | 47 ++++
 rtl/rd_rsp_inorder_fetch.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rd_rsp_inorder_fetch_pkg.sv
// Shared types and helpers for the in-order read-response fetch unit.
// Tag/beat geometry defaults and the drain FSM encoding live here.
package rd_rsp_inorder_fetch_pkg;

  localparam int TAG_NUM_LOG   = 6;
  localparam int DMA_DATA_W    = 256;
  localparam int DMA_W_BCNT    = 32;
  localparam int DMA_LEN_WIDTH = 13;

  typedef enum logic [1:0] {
    RIF_IDLE  = 2'd0,
    RIF_WAIT  = 2'd1,
    RIF_FETCH = 2'd2,
    RIF_DRAIN = 2'd3
  } rif_state_e;

  // A zero-length request still moves one beat.
  function automatic logic [31:0] blen2beats(
    input logic [31:0] blen,
    input int          bcnt_log
  );
    if (blen == 32'd0) return 32'd1;
    return (blen + ((32'd1 << bcnt_log) - 32'd1)) >> bcnt_log;
  endfunction

endpackage

// File: rtl/rd_rsp_inorder_fetch_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Pushes while full and pops while empty are ignored.
module rd_rsp_inorder_fetch_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rd_rsp_inorder_fetch.sv
// Drains DMA read tags in issue order from the reorder buffer fetch port
// into a valid/ready stream, releasing each tag once its last beat lands.
import rd_rsp_inorder_fetch_pkg::*;

module rd_rsp_inorder_fetch #(
  parameter int TAG_LOG   = TAG_NUM_LOG,
  parameter int DATA_W    = DMA_DATA_W,
  parameter int BCNT      = DMA_W_BCNT,
  parameter int LEN_W     = DMA_LEN_WIDTH,
  parameter int ORD_DEPTH = 2**TAG_LOG,
  parameter int OUT_DEPTH = 4
) (
  input  logic               dma_clk,
  input  logic               rst,
  input  logic               alloc_vld,
  input  logic [TAG_LOG-1:0] alloc_tag,
  input  logic [LEN_W-1:0]   alloc_blen,
  output logic               alloc_rdy,
  input  logic               cpl_vld,
  input  logic [TAG_LOG-1:0] cpl_tag,
  output logic               ft_rd_rsp_ren,
  output logic [TAG_LOG-1:0] ft_rd_rsp_tag,
  input  logic [DATA_W-1:0]  ft_rd_rsp_data,
  input  logic               ft_rd_rsp_last,
  input  logic               ft_rd_rsp_vld,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_LOG-1:0] out_tag,
  output logic               out_last,
  input  logic               out_ready,
  output logic               rel_vld,
  output logic [TAG_LOG-1:0] rel_tag,
  output logic [2:0]         err_flags,
  output logic               idle
);

  localparam int BLOG  = $clog2(BCNT);
  localparam int CNT_W = LEN_W - BLOG + 1;
  localparam int OW    = TAG_LOG + CNT_W;
  localparam int BW    = DATA_W + TAG_LOG + 1;
  localparam int QCW   = $clog2(ORD_DEPTH+1);
  localparam int OCW   = $clog2(OUT_DEPTH+1);

  rif_state_e           state;
  logic [2**TAG_LOG-1:0] done;
  logic [CNT_W-1:0]     issue_cnt;
  logic [CNT_W-1:0]     ret_cnt;
  logic [OCW-1:0]       inflight;
  logic                 armed;

  logic [OW-1:0]        ord_dout;
  logic                 ord_empty;
  logic [QCW-1:0]       ord_cnt;
  logic                 ord_push;
  logic                 ord_pop;
  logic [TAG_LOG-1:0]   head_tag;
  logic [CNT_W-1:0]     head_beats;
  logic [CNT_W-1:0]     beats_m1;
  logic [CNT_W-1:0]     alloc_beats;

  logic [BW-1:0]        ob_dout;
  logic                 ob_empty;
  logic [OCW-1:0]       ob_cnt;
  logic                 ob_pop;

  logic                 ren;
  logic                 credit_ok;
  logic                 beat_acc;
  logic                 beat_last;

  assign alloc_rdy   = (ord_cnt != QCW'(ORD_DEPTH));
  assign ord_push    = alloc_vld && alloc_rdy;
  assign alloc_beats = CNT_W'(blen2beats(32'(alloc_blen), BLOG));
  assign head_tag    = ord_dout[OW-1 -: TAG_LOG];
  assign head_beats  = ord_dout[CNT_W-1:0];
  assign beats_m1    = head_beats - CNT_W'(1);

  // Outstanding fetches count against buffer space so it never overflows.
  assign credit_ok = ((OCW+1)'(ob_cnt) + (OCW+1)'(inflight))
                     < (OCW+1)'(OUT_DEPTH);
  assign ren       = (state == RIF_FETCH) && credit_ok;
  assign beat_acc  = ft_rd_rsp_vld && (inflight != '0);
  assign beat_last = (ret_cnt == beats_m1);
  assign ord_pop   = beat_acc && beat_last;

  assign ft_rd_rsp_ren = ren;
  assign ft_rd_rsp_tag = ren ? head_tag : '0;

  assign out_valid = !ob_empty;
  assign ob_pop    = out_valid && out_ready;
  assign out_data  = out_valid ? ob_dout[BW-1 -: DATA_W] : '0;
  assign out_tag   = out_valid ? ob_dout[TAG_LOG:1] : '0;
  assign out_last  = out_valid && ob_dout[0];

  assign idle = ord_empty && (inflight == '0) && ob_empty;

  rd_rsp_inorder_fetch_sync_fifo #(
    .W     (OW),
    .DEPTH (ORD_DEPTH)
  ) u_ord_q (
    .clk   (dma_clk),
    .rst   (rst),
    .push  (ord_push),
    .din   ({alloc_tag, alloc_beats}),
    .pop   (ord_pop),
    .dout  (ord_dout),
    .empty (ord_empty),
    .count (ord_cnt)
  );

  rd_rsp_inorder_fetch_sync_fifo #(
    .W     (BW),
    .DEPTH (OUT_DEPTH)
  ) u_out_q (
    .clk   (dma_clk),
    .rst   (rst),
    .push  (beat_acc),
    .din   ({ft_rd_rsp_data, head_tag, beat_last}),
    .pop   (ob_pop),
    .dout  (ob_dout),
    .empty (ob_empty),
    .count (ob_cnt)
  );

  // Completion set is applied after release clear so it wins on a collision.
  always_ff @(posedge dma_clk) begin
    if (rst) begin
      done <= '0;
    end else begin
      if (ord_pop) done[head_tag] <= 1'b0;
      if (cpl_vld) done[cpl_tag]  <= 1'b1;
    end
  end

  always_ff @(posedge dma_clk) begin
    if (rst) begin
      state     <= RIF_IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      inflight  <= '0;
      armed     <= 1'b0;
      rel_vld   <= 1'b0;
      rel_tag   <= '0;
      err_flags <= '0;
    end else begin
      rel_vld  <= ord_pop;
      rel_tag  <= ord_pop ? head_tag : '0;
      inflight <= inflight + OCW'(ren) - OCW'(beat_acc);
      if (ren) armed <= 1'b1;
      if (beat_acc) begin
        ret_cnt <= beat_last ? '0 : ret_cnt + CNT_W'(1);
        if (ft_rd_rsp_last != beat_last) err_flags[0] <= 1'b1;
      end
      if (cpl_vld && done[cpl_tag]) err_flags[1] <= 1'b1;
      // Beats before the first post-reset fetch are stale, not errors.
      if (ft_rd_rsp_vld && inflight == '0 && armed) err_flags[2] <= 1'b1;
      unique case (state)
        RIF_IDLE: begin
          if (!ord_empty) state <= RIF_WAIT;
        end
        RIF_WAIT: begin
          if (ord_empty)           state <= RIF_IDLE;
          else if (done[head_tag]) state <= RIF_FETCH;
        end
        RIF_FETCH: begin
          if (ren) begin
            if (issue_cnt == beats_m1) begin
              issue_cnt <= '0;
              state     <= RIF_DRAIN;
            end else begin
              issue_cnt <= issue_cnt + CNT_W'(1);
            end
          end
        end
        RIF_DRAIN: begin
          if (ord_pop) state <= RIF_WAIT;
        end
        default: state <= RIF_IDLE;
      endcase
    end
  end

endmodule
